// File: rtl/pipeline_stall_ctrl.sv
// Pipeline interlock responder: owns IF/ID and ID/EX, applies stall/flush.
// Counts stall bubbles and flags runaway stalls.
module pipeline_stall_ctrl #(
  parameter int          PC_W       = 16,
  parameter logic [3:0]  NOP_OPCODE = 4'hF,
  parameter int          MAX_STALL  = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [15:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_valid,
  input  logic            hazard_stall,
  input  logic            branch_flush,
  output logic            pc_write,
  output logic [15:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc,
  output logic            if_id_valid,
  output logic [3:0]      id_ex_opcode,
  output logic [3:0]      id_ex_dest,
  output logic [3:0]      id_ex_op1,
  output logic [3:0]      id_ex_op2,
  output logic            id_ex_valid,
  output logic [15:0]     stall_count,
  output logic            stall_timeout,
  output logic [1:0]      state
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    FLUSHED = 2'd2
  } state_t;

  localparam logic [15:0] NOP_INSTR = {NOP_OPCODE, 12'h000};
  localparam logic [7:0]  MAX_C     = 8'(MAX_STALL);

  state_t     st;
  logic       stall_eff;
  logic       advance;
  logic [7:0] consec;
  logic [7:0] consec_inc;

  assign stall_eff  = hazard_stall & if_id_valid & ~branch_flush;
  assign advance    = ~branch_flush & ~stall_eff;
  assign pc_write   = reset | ~stall_eff;
  assign consec_inc = (consec == 8'hFF) ? consec : consec + 8'd1;
  assign state      = st;

  // Pipeline registers: flush squashes both, stall bubbles ID/EX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_id_instr  <= NOP_INSTR;
      if_id_pc     <= '0;
      if_id_valid  <= 1'b0;
      id_ex_opcode <= NOP_OPCODE;
      id_ex_dest   <= 4'h0;
      id_ex_op1    <= 4'h0;
      id_ex_op2    <= 4'h0;
      id_ex_valid  <= 1'b0;
    end else begin
      unique case (1'b1)
        branch_flush: begin
          if_id_instr  <= NOP_INSTR;
          if_id_valid  <= 1'b0;
          id_ex_opcode <= NOP_OPCODE;
          id_ex_dest   <= 4'h0;
          id_ex_op1    <= 4'h0;
          id_ex_op2    <= 4'h0;
          id_ex_valid  <= 1'b0;
        end
        stall_eff: begin
          id_ex_opcode <= NOP_OPCODE;
          id_ex_dest   <= 4'h0;
          id_ex_op1    <= 4'h0;
          id_ex_op2    <= 4'h0;
          id_ex_valid  <= 1'b0;
        end
        advance: begin
          if_id_instr <= if_instr;
          if_id_pc    <= if_pc;
          if_id_valid <= if_valid;
          if (if_id_valid) begin
            id_ex_opcode <= if_id_instr[15:12];
            id_ex_dest   <= if_id_instr[11:8];
            id_ex_op1    <= if_id_instr[7:4];
            id_ex_op2    <= if_id_instr[3:0];
          end else begin
            id_ex_opcode <= NOP_OPCODE;
            id_ex_dest   <= 4'h0;
            id_ex_op1    <= 4'h0;
            id_ex_op2    <= 4'h0;
          end
          id_ex_valid <= if_id_valid;
        end
        default: ;
      endcase
    end
  end

  // Bubble statistics: total count, consecutive run and sticky timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count   <= 16'h0000;
      consec        <= 8'h00;
      stall_timeout <= 1'b0;
    end else if (stall_eff) begin
      if (stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
      consec <= consec_inc;
      if (consec_inc == MAX_C)
        stall_timeout <= 1'b1;
    end else begin
      consec <= 8'h00;
    end
  end

  // Interlock state: flush dominates, then stall, else run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= RUN;
    end else begin
      unique case (1'b1)
        branch_flush: st <= FLUSHED;
        stall_eff:    st <= STALL;
        advance:      st <= RUN;
        default:      st <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized bench for pipeline_stall_ctrl with a cycle-level reference model.
// Directed literal checks pin the model on the documented scenarios.
module tb_pipeline_stall_ctrl;

  localparam int MAXS = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        hazard_stall;
  logic        branch_flush;
  logic        pc_write;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic        if_id_valid;
  logic [3:0]  id_ex_opcode;
  logic [3:0]  id_ex_dest;
  logic [3:0]  id_ex_op1;
  logic [3:0]  id_ex_op2;
  logic        id_ex_valid;
  logic [15:0] stall_count;
  logic        stall_timeout;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [15:0] m_ii;
  logic [15:0] m_ip;
  logic        m_iv;
  logic [15:0] m_ex;
  logic        m_ev;
  int          m_cnt;
  int          m_con;
  logic        m_to;
  int          m_st;

  always #5 clock = ~clock;

  pipeline_stall_ctrl #(
    .PC_W(16),
    .NOP_OPCODE(4'hF),
    .MAX_STALL(MAXS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .if_valid(if_valid),
    .hazard_stall(hazard_stall),
    .branch_flush(branch_flush),
    .pc_write(pc_write),
    .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid),
    .id_ex_opcode(id_ex_opcode),
    .id_ex_dest(id_ex_dest),
    .id_ex_op1(id_ex_op1),
    .id_ex_op2(id_ex_op2),
    .id_ex_valid(id_ex_valid),
    .stall_count(stall_count),
    .stall_timeout(stall_timeout),
    .state(state)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ii  = 16'hF000;
    m_ip  = 16'h0000;
    m_iv  = 1'b0;
    m_ex  = 16'hF000;
    m_ev  = 1'b0;
    m_cnt = 0;
    m_con = 0;
    m_to  = 1'b0;
    m_st  = 0;
  endtask

  function automatic bit model_stall();
    return hazard_stall && m_iv && !branch_flush;
  endfunction

  // one clock edge worth of the interlock rules
  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (branch_flush) begin
      m_ii  = 16'hF000;
      m_iv  = 1'b0;
      m_ex  = 16'hF000;
      m_ev  = 1'b0;
      m_con = 0;
      m_st  = 2;
    end else if (model_stall()) begin
      m_ex  = 16'hF000;
      m_ev  = 1'b0;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_con = (m_con < 255) ? m_con + 1 : 255;
      if (m_con == MAXS) m_to = 1'b1;
      m_st  = 1;
    end else begin
      m_ex  = m_iv ? m_ii : 16'hF000;
      m_ev  = m_iv;
      m_ii  = if_instr;
      m_ip  = if_pc;
      m_iv  = if_valid;
      m_con = 0;
      m_st  = 0;
    end
  endtask

  task automatic drive(input logic [15:0] i, input logic [15:0] p,
                       input logic v, input logic hs, input logic bf);
    if_instr     = i;
    if_pc        = p;
    if_valid     = v;
    hazard_stall = hs;
    branch_flush = bf;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (chk_en) begin
      check("pc_write", 32'(pc_write), 32'(reset || !model_stall()));
      check("if_id_instr", 32'(if_id_instr), 32'(m_ii));
      check("if_id_pc", 32'(if_id_pc), 32'(m_ip));
      check("if_id_valid", 32'(if_id_valid), 32'(m_iv));
      check("id_ex_fields",
            32'({id_ex_opcode, id_ex_dest, id_ex_op1, id_ex_op2}),
            32'(m_ex));
      check("id_ex_valid", 32'(id_ex_valid), 32'(m_ev));
      check("stall_count", 32'(stall_count), 32'(m_cnt));
      check("stall_timeout", 32'(stall_timeout), 32'(m_to));
      check("state", 32'(state), 32'(m_st));
    end
  end

  initial begin
    reset = 1'b1;
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    chk_en = 1'b1;
    repeat (2) tick();
    check("rst_pc_write", 32'(pc_write), 32'd1);
    check("rst_state", 32'(state), 32'd0);
    check("rst_if_id_instr", 32'(if_id_instr), 32'hF000);
    check("rst_id_ex_opcode", 32'(id_ex_opcode), 32'hF);
    check("rst_if_id_valid", 32'(if_id_valid), 32'd0);
    check("rst_stall_count", 32'(stall_count), 32'd0);
    reset = 1'b0;

    // stall ignored while IF/ID is empty
    drive(16'h0123, 16'h0010, 1'b1, 1'b1, 1'b0);
    #1 check("empty_pc_write", 32'(pc_write), 32'd1);
    drive(16'h0123, 16'h0010, 1'b1, 1'b0, 1'b0);
    tick();
    check("a_if_id_instr", 32'(if_id_instr), 32'h0123);
    check("a_if_id_pc", 32'(if_id_pc), 32'h0010);
    check("a_if_id_valid", 32'(if_id_valid), 32'd1);
    check("a_count0", 32'(stall_count), 32'd0);

    drive(16'h1456, 16'h0011, 1'b1, 1'b0, 1'b0);
    tick();
    check("a_ex_fields",
          32'({id_ex_opcode, id_ex_dest, id_ex_op1, id_ex_op2}),
          32'h0123);
    check("a_ex_valid", 32'(id_ex_valid), 32'd1);
    check("b_if_id_instr", 32'(if_id_instr), 32'h1456);

    // two-cycle stall on B
    drive(16'h2789, 16'h0012, 1'b1, 1'b1, 1'b0);
    #1 check("stall_pc_write", 32'(pc_write), 32'd0);
    tick();
    check("s1_if_id", 32'(if_id_instr), 32'h1456);
    check("s1_ex_op", 32'(id_ex_opcode), 32'hF);
    check("s1_ex_valid", 32'(id_ex_valid), 32'd0);
    check("s1_count", 32'(stall_count), 32'd1);
    check("s1_state", 32'(state), 32'd1);
    tick();
    check("s2_count", 32'(stall_count), 32'd2);
    check("s2_if_id", 32'(if_id_instr), 32'h1456);
    drive(16'h2789, 16'h0012, 1'b1, 1'b0, 1'b0);
    tick();
    check("rel_ex_fields",
          32'({id_ex_opcode, id_ex_dest, id_ex_op1, id_ex_op2}),
          32'h1456);
    check("rel_state", 32'(state), 32'd0);
    check("rel_if_id", 32'(if_id_instr), 32'h2789);

    // flush together with stall
    drive(16'h3ABC, 16'h0013, 1'b1, 1'b1, 1'b1);
    #1 check("fl_pc_write", 32'(pc_write), 32'd1);
    tick();
    check("fl_if_id_valid", 32'(if_id_valid), 32'd0);
    check("fl_ex_valid", 32'(id_ex_valid), 32'd0);
    check("fl_count", 32'(stall_count), 32'd2);
    check("fl_state", 32'(state), 32'd2);
    drive(16'h4DEF, 16'h0014, 1'b1, 1'b1, 1'b0);
    #1 check("pf_pc_write", 32'(pc_write), 32'd1);
    tick();
    check("pf_state", 32'(state), 32'd0);
    check("pf_count", 32'(stall_count), 32'd2);
    check("pf_if_id", 32'(if_id_instr), 32'h4DEF);

    // runaway stall
    drive(16'h5000, 16'h0015, 1'b1, 1'b1, 1'b0);
    repeat (MAXS - 1) tick();
    check("to_before", 32'(stall_timeout), 32'd0);
    check("to_count7", 32'(stall_count), 32'd9);
    tick();
    check("to_rise", 32'(stall_timeout), 32'd1);
    check("to_count8", 32'(stall_count), 32'd10);
    drive(16'h5000, 16'h0015, 1'b1, 1'b0, 1'b0);
    tick();
    check("to_rel_state", 32'(state), 32'd0);
    drive(16'h6000, 16'h0016, 1'b1, 1'b0, 1'b1);
    tick();
    check("to_fl_state", 32'(state), 32'd2);
    check("to_sticky1", 32'(stall_timeout), 32'd1);
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    check("to_sticky2", 32'(stall_timeout), 32'd1);
    check("fl_exit_state", 32'(state), 32'd0);

    // asynchronous reset in the middle of a stall
    drive(16'h7111, 16'h0017, 1'b1, 1'b0, 1'b0);
    tick();
    drive(16'h7222, 16'h0018, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check("mid_count", 32'(stall_count), 32'd12);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("ar_pc_write", 32'(pc_write), 32'd1);
    check("ar_state", 32'(state), 32'd0);
    check("ar_count", 32'(stall_count), 32'd0);
    check("ar_timeout", 32'(stall_timeout), 32'd0);
    check("ar_if_id_valid", 32'(if_id_valid), 32'd0);
    check("ar_ex_op", 32'(id_ex_opcode), 32'hF);
    tick();
    reset = 1'b0;

    // randomized traffic, second half stall-heavy
    for (int n = 0; n < 600; n++) begin
      logic [15:0] ri;
      logic [15:0] rp;
      logic        rv;
      logic        rh;
      logic        rf;
      ri = 16'($urandom);
      rp = 16'($urandom);
      rv = ($urandom_range(3) != 0);
      if (n < 300) rh = ($urandom_range(2) == 0);
      else         rh = ($urandom_range(15) != 0);
      rf = ($urandom_range(11) == 0);
      drive(ri, rp, rv, rh, rf);
      tick();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Responder side of the pipeline interlock. It consumes the combinational stall request from the hazard detector and the branch flush. It owns the IF/ID and ID/EX pipeline registers, and on request it holds PC and IF/ID, injects a NOP bubble into ID/EX, or squashes both stages. It also counts bubbles and flags runaway stalls.

Parameters:
PC_W, 16, width of program counter field
NOP_OPCODE, 4'hF, opcode written into a bubble
MAX_STALL, 8, consecutive stall cycles that raise stall_timeout (legal range 1..255)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
if_instr  in  16  fetched instruction: [15:12] opcode, [11:8] dest, [7:4] op1, [3:0] op2
if_pc  in  PC_W  PC of fetched instruction
if_valid  in  1  fetched instruction is real
hazard_stall  in  1  stall request from hazard detector (evaluated on current IF/ID contents)
branch_flush  in  1  squash IF/ID and ID/EX this cycle
pc_write  out  1  PC update enable (combinational)
if_id_instr  out  16  IF/ID instruction register
if_id_pc  out  PC_W  IF/ID PC register
if_id_valid  out  1  IF/ID valid
id_ex_opcode  out  4  ID/EX opcode
id_ex_dest  out  4  ID/EX destination register
id_ex_op1  out  4  ID/EX source 1
id_ex_op2  out  4  ID/EX source 2
id_ex_valid  out  1  ID/EX valid
stall_count  out  16  total bubbles inserted by stalls, saturates at 16'hFFFF
stall_timeout  out  1  sticky: MAX_STALL consecutive stalls seen
state  out  2  FSM state: 0 RUN, 1 STALL, 2 FLUSHED

Behaviour:
- Reset (async, any time, including mid-stall):
  - IF/ID and ID/EX hold bubbles: instr = {NOP_OPCODE,12'h000}; opcode = NOP_OPCODE; dest/op1/op2 = 0; valid = 0.
  - if_id_pc = 0, stall_count = 0, stall_timeout = 0, internal consecutive counter = 0, state = RUN.
- Effective stall: stall_eff = hazard_stall & if_id_valid & ~branch_flush. hazard_stall is ignored when IF/ID is invalid.
- pc_write = ~stall_eff. It is combinational, zero latency, and is 1 during reset.
- Per-edge priority: flush > stall > advance.
  - Advance:
    - IF/ID <= {if_instr, if_pc, if_valid}.
    - ID/EX <= fields of the current IF/ID and if_id_valid.
    - An invalid IF/ID propagates as a bubble (opcode NOP_OPCODE, fields 0).
  - Stall:
    - IF/ID holds.
    - ID/EX <= bubble.
    - stall_count += 1, saturating.
    - Consecutive counter += 1, saturating at 255.
  - Flush:
    - IF/ID <= bubble, valid 0.
    - ID/EX <= bubble.
    - Consecutive counter <= 0.
    - stall_count unchanged.
- Latency: an instruction enters IF/ID one edge after fetch. It reaches ID/EX one edge later, plus one edge per stall cycle.
- FSM:
  - RUN -> STALL on stall_eff.
  - RUN -> FLUSHED on branch_flush.
  - STALL stays while stall_eff.
  - STALL -> RUN on advance; the consecutive counter clears on the same edge.
  - STALL -> FLUSHED on branch_flush.
  - FLUSHED lasts exactly one cycle, then goes to STALL if stall_eff, else RUN. Stall is impossible in that cycle because IF/ID is invalid, so in practice the exit is to RUN unless a new flush re-enters FLUSHED.
- Timeout:
  - On the edge where the consecutive counter becomes MAX_STALL, stall_timeout <= 1.
  - It remains 1 until reset.
  - Stalling continues to follow inputs; no forced release.
- Simultaneous events:
  - flush + stall: flush wins; no bubble count.
  - flush + if_valid: the fetched instruction is discarded.
  - Stall with if_valid=1: the fetched instruction is not captured. The fetch stage must re-present it, which it does because PC is held.

Test Plan:
- Reset, then fetch A=16'h0123, pc=0x10, then B=16'h1456 -> if_id_instr=0123 after edge 1; id_ex_opcode=0, dest=1, op1=2, op2=3, valid=1 after edge 2; pc_write=1 throughout.
- With A in IF/ID, hold hazard_stall=1 for 2 cycles -> pc_write=0, IF/ID holds 0123, ID/EX is bubble (opcode F, valid 0) for 2 edges, stall_count=2, state=STALL; drop stall -> A reaches ID/EX next edge, state=RUN.
- hazard_stall=1 and branch_flush=1 together -> both stages become bubbles, pc_write=1, stall_count unchanged, state=FLUSHED for one cycle then RUN.
- hazard_stall=1 while if_id_valid=0 -> no stall, pc_write=1, stall_count=0.
- MAX_STALL=8, stall for 8 cycles -> stall_timeout rises on the 8th edge; release then flush -> stall_timeout stays 1 until reset.
- Assert reset asynchronously mid-stall (between edges) -> outputs return to reset values immediately, pc_write=1, state=RUN, stall_count=0.
